// File: rtl/mul_seq_pkg.sv
// Shared ALU multi-cycle unit definitions: control states, native width and
// a two's-complement negate helper used by the multiplier and divider.
package mul_seq_pkg;

  localparam int XLEN  = 32;
  // Widest value the negate helper handles: a full double-width product.
  localparam int NEG_W = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } alu_state_e;

  // Two's-complement negate at NEG_W bits. Narrower callers zero-extend the
  // operand and keep the low bits, which equal the negate at their own width.
  function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] v);
    return -v;
  endfunction

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, signed or
// unsigned per operation, fixed WIDTH+1 cycle latency, start/busy/drdy handshake.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signctl,
  input  logic             high_out,
  input  logic             start,
  output logic             busy,
  output logic             drdy,
  output logic [WIDTH-1:0] Y
);

  // One extra bit so the counter can reach WIDTH before wrapping.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  alu_state_e         state;
  alu_state_e         state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               drdy_q;
  logic [2*WIDTH-1:0] product;

  // Operand magnitudes and sign are latched on accept; the multiplier
  // register doubles as the low half of the accumulator as it shifts out.
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   mplr;
  logic               neg;

  logic               accept;
  logic               last_step;
  logic [WIDTH:0]     sum;
  logic [NEG_W-1:0]   neg_p;

  assign accept    = start && (state == IDLE);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state != IDLE);
  assign drdy      = drdy_q;
  assign Y         = high_out ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];

  // Conditional add of the multiplicand into the upper half; bit WIDTH is the
  // carry that shifts back into the accumulator MSB.
  assign sum   = {1'b0, acc_hi} + (mplr[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign neg_p = twos_neg(NEG_W'({acc_hi, mplr}));

  // Next-state: IDLE -> RUN on accept, RUN for WIDTH steps, one FIX cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, step counter, result pulse and held product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      drdy_q  <= 1'b0;
      product <= '0;
    end else begin
      state  <= state_nxt;
      drdy_q <= (state == FIX);
      if (state == FIX) begin
        product <= neg ? neg_p[2*WIDTH-1:0] : {acc_hi, mplr};
      end
      if (accept || (state == FIX)) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Datapath: latch magnitudes on accept, then add-and-shift once per RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand  <= (signctl && A[WIDTH-1]) ? -A : A;
      mplr   <= (signctl && B[WIDTH-1]) ? -B : B;
      acc_hi <= '0;
      neg    <= signctl && (A[WIDTH-1] ^ B[WIDTH-1]);
    end else if (state == RUN) begin
      acc_hi <= sum[WIDTH:1];
      mplr   <= {sum[0], mplr[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases, handshake behaviour,
// asynchronous reset mid-operation and randomized operands against an
// arithmetic reference product.
module tb_mul_seq;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic        signctl;
  logic        high_out;
  logic        start;
  logic        busy;
  logic        drdy;
  logic [31:0] Y;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  mul_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .signctl  (signctl),
    .high_out (high_out),
    .start    (start),
    .busy     (busy),
    .drdy     (drdy),
    .Y        (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product from plain integer arithmetic.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_y(input string tag, input logic [63:0] exp);
    high_out = 1'b0;
    #1;
    check($sformatf("%s.lo", tag), 64'(Y), {32'b0, exp[31:0]});
    high_out = 1'b1;
    #1;
    check($sformatf("%s.hi", tag), 64'(Y), {32'b0, exp[63:32]});
    high_out = 1'b0;
  endtask

  // Called in the low clock phase; returns at the negedge after the accept edge.
  task automatic begin_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    A       = a;
    B       = b;
    signctl = s;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges from accept until drdy, scrambling operands while running and
  // optionally re-asserting start at edge 'inject'. Bounded to 100 edges.
  task automatic wait_done(input int inject, output int lat, output int nbusy);
    lat   = 0;
    nbusy = (busy === 1'b1) ? 1 : 0;
    while (drdy !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (drdy !== 1'b1) begin
        if (busy === 1'b1) nbusy++;
        A       = $urandom;
        B       = $urandom;
        signctl = 1'($urandom);
        start   = (lat == inject);
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input int inject);
    logic [63:0] exp;
    int          lat;
    int          nb;
    exp = ref_mul(a, b, s);
    begin_op(a, b, s);
    wait_done(inject, lat, nb);
    check($sformatf("%s.latency", tag), 64'(lat), 64'd33);
    check($sformatf("%s.busy_cycles", tag), 64'(nb), 64'd33);
    check($sformatf("%s.busy_at_drdy", tag), 64'(busy), 64'd0);
    check_y(tag, exp);
    @(negedge clk);
    check($sformatf("%s.drdy_pulse", tag), 64'(drdy), 64'd0);
    check_y($sformatf("%s.hold", tag), exp);
  endtask

  initial begin
    int          lat;
    int          nb;
    int          seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    rst      = 1'b1;
    start    = 1'b0;
    A        = '0;
    B        = '0;
    signctl  = 1'b0;
    high_out = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.drdy", 64'(drdy), 64'd0);
    check_y("reset.y", 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("u_7x6",        32'd7,          32'd6,          1'b0, -1);
    do_op("u_max_sq",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, -1);
    do_op("s_m3x5",       32'hFFFF_FFFD,  32'd5,          1'b1, -1);
    do_op("u_m3x5",       32'hFFFF_FFFD,  32'd5,          1'b0, -1);
    do_op("s_min_sq",     32'h8000_0000,  32'h8000_0000,  1'b1, -1);
    do_op("s_min_x1",     32'h8000_0000,  32'd1,          1'b1, -1);
    do_op("s_neg_x_neg",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, -1);
    do_op("s_zero",       32'd0,          32'h8000_0000,  1'b1, -1);
    do_op("busy_ignore",  32'h1234_5678,  32'h9ABC_DEF0,  1'b0, 10);

    // Back-to-back: start held on the drdy cycle of the previous op.
    begin_op(32'hDEAD_BEEF, 32'h0000_0100, 1'b0);
    wait_done(-1, lat, nb);
    check("b2b.first_latency", 64'(lat), 64'd33);
    check_y("b2b.first", ref_mul(32'hDEAD_BEEF, 32'h0000_0100, 1'b0));
    begin_op(32'd3, 32'd4, 1'b0);
    check("b2b.no_second_pulse", 64'(drdy), 64'd0);
    check("b2b.busy_again", 64'(busy), 64'd1);
    wait_done(-1, lat, nb);
    check("b2b.second_latency", 64'(lat), 64'd33);
    check_y("b2b.second", 64'h0000_0000_0000_000C);

    // Asynchronous reset between edges at cycle 12 of 9*9.
    @(negedge clk);
    begin_op(32'd9, 32'd9, 1'b0);
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("rst_mid.busy_before", 64'(busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.drdy", 64'(drdy), 64'd0);
    high_out = 1'b0;
    #0;
    check("rst_mid.y_lo", 64'(Y), 64'd0);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (drdy === 1'b1) seen++;
    end
    check("rst_mid.no_drdy", 64'(seen), 64'd0);
    do_op("rst_fresh", 32'd9, 32'd9, 1'b0, -1);
    check_y("rst_fresh.value", 64'h51);

    // Randomized operands, with boundary values mixed in.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      if (i % 5 == 1) ra = 32'h8000_0000;
      if (i % 7 == 2) rb = 32'hFFFF_FFFF;
      do_op($sformatf("rand%0d", i), ra, rb, rs, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
